car_row_ctrl: RTL and testbench

CAR_ROW_CTRL -- requirements
Module: car_row_ctrl

---
 rtl/car_row_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_car_row_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/car_row_ctrl.sv
// car_row_ctrl
//   Moves one lane of cars once per video frame and checks the lane for
//   overlap with the frog. Each accepted frame walks MOVE (one car per
//   cycle), CHECK (one car per cycle) and DONE (publish Collision).
//
// Ports
//   Clk, Reset        system clock, synchronous active-high reset
//   frame_clk         vsync frame tick, asynchronous to Clk
//   Enable            1 = lane advances on frame ticks
//   FrogX/FrogY       frog bounding box top-left
//   Frog_Width/Height frog bounding box size
//   Car_X, Car_Y      per-slot car left edge (11-bit two's complement) / top
//   Number_Cars       constant NUM_CARS
//   Collision         registered frog/car overlap result of the last update
//   Busy              high while a frame update is being processed
module car_row_ctrl #(
  parameter logic [10:0] ROW_Y    = 11'd280,
  parameter int unsigned NUM_CARS = 3,
  parameter int unsigned SPEED    = 2,
  parameter bit          DIR      = 1'b0,
  parameter int unsigned START_X  = 0,
  parameter int unsigned SPACING  = 213
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             Enable,
  input  logic [10:0]      FrogX,
  input  logic [10:0]      FrogY,
  input  logic [10:0]      Frog_Width,
  input  logic [10:0]      Frog_Height,
  output logic [3:0][10:0] Car_X,
  output logic [3:0][10:0] Car_Y,
  output logic [2:0]       Number_Cars,
  output logic             Collision,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_MOVE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [1:0]  LAST_IDX = 2'(NUM_CARS - 1);
  localparam logic [10:0] STEP     = 11'(SPEED);
  localparam logic [11:0] CAR_BOT  = {1'b0, ROW_Y} + 12'd40;

  function automatic logic [10:0] reset_x(input int unsigned i);
    return (i < NUM_CARS) ? 11'((START_X + i * SPACING) % 640) : '0;
  endfunction

  // Wrap points place a car fully off-screen (80 px wide) on the far side.
  function automatic logic [10:0] move_car(input logic [10:0] x);
    logic [10:0] nx;
    if (DIR == 1'b0) begin
      nx = x + STEP;
      if (nx >= 11'd640 && nx <= 11'd1023) nx = nx - 11'd720;
    end else begin
      nx = x - STEP;
      // +720 modulo 2048 is the same as +720-2048 for this range
      if (nx >= 11'd1024 && nx <= 11'd1968) nx = nx + 11'd720;
    end
    return nx;
  endfunction

  logic [1:0]       sync_q;
  logic             prev_q;
  logic             rise_q;
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             acc_q, acc_d;
  logic             coll_q, coll_d;
  logic [10:0]      frog_x_q, frog_x_d;
  logic [10:0]      frog_y_q, frog_y_d;
  logic [10:0]      frog_w_q, frog_w_d;
  logic [10:0]      frog_h_q, frog_h_d;
  logic [3:0][10:0] car_q, car_d;

  logic [10:0]      cur_x;
  logic [10:0]      left_x;
  logic [10:0]      right_x;
  logic             hit;

  // Synchronizer plus edge register: rise_q pulses for one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], frame_clk};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  // Overlap test against the latched frog box; negative X clamps left edge to 0.
  always_comb begin
    cur_x   = car_q[idx_q];
    left_x  = cur_x[10] ? '0 : cur_x;
    right_x = cur_x + 11'd80;
    hit = (frog_x_q <= right_x) &&
          ({1'b0, left_x} <= ({1'b0, frog_x_q} + {1'b0, frog_w_q})) &&
          ({1'b0, frog_y_q} <= CAR_BOT) &&
          ({1'b0, ROW_Y} <= ({1'b0, frog_y_q} + {1'b0, frog_h_q}));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    coll_d   = coll_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    frog_w_d = frog_w_q;
    frog_h_d = frog_h_q;
    car_d    = car_q;
    case (state_q)
      S_WAIT: begin
        if (rise_q && Enable) begin
          state_d  = S_MOVE;
          idx_d    = '0;
          acc_d    = 1'b0;
          frog_x_d = FrogX;
          frog_y_d = FrogY;
          frog_w_d = Frog_Width;
          frog_h_d = Frog_Height;
        end
      end
      S_MOVE: begin
        car_d[idx_q] = move_car(cur_x);
        if (idx_q == LAST_IDX) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_CHECK: begin
        acc_d = acc_q | hit;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        coll_d  = acc_q;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_WAIT;
      idx_q    <= '0;
      acc_q    <= 1'b0;
      coll_q   <= 1'b0;
      frog_x_q <= '0;
      frog_y_q <= '0;
      frog_w_q <= '0;
      frog_h_q <= '0;
      for (int unsigned i = 0; i < 4; i++) car_q[i] <= reset_x(i);
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      coll_q   <= coll_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      frog_w_q <= frog_w_d;
      frog_h_q <= frog_h_d;
      car_q    <= car_d;
    end
  end

  // The accepting cycle in WAIT already counts as busy, so Busy spans
  // detection through DONE (2*NUM_CARS + 2 cycles).
  assign Busy        = (state_q != S_WAIT) || (rise_q && Enable);
  assign Collision   = coll_q;
  assign Car_X       = car_q;
  assign Number_Cars = 3'(NUM_CARS);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) Car_Y[i] = (i < NUM_CARS) ? ROW_Y : '0;
  end

endmodule

// File: tb/tb_car_row_ctrl.sv
module tb_car_row_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             Reset, frame_clk, Enable;
  logic [10:0]      FrogX, FrogY, FrogW, FrogH;
  logic [3:0][10:0] cx0, cy0, cx1, cy1;
  logic [2:0]       nc0, nc1;
  logic             coll0, busy0, coll1, busy1;

  car_row_ctrl dut0 (
    .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .Enable(Enable),
    .FrogX(FrogX), .FrogY(FrogY), .Frog_Width(FrogW), .Frog_Height(FrogH),
    .Car_X(cx0), .Car_Y(cy0), .Number_Cars(nc0), .Collision(coll0), .Busy(busy0)
  );

  car_row_ctrl #(.NUM_CARS(4), .DIR(1'b1), .SPACING(200)) dut1 (
    .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .Enable(Enable),
    .FrogX(FrogX), .FrogY(FrogY), .Frog_Width(FrogW), .Frog_Height(FrogH),
    .Car_X(cx1), .Car_Y(cy1), .Number_Cars(nc1), .Collision(coll1), .Busy(busy1)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain integer positions and collision flags.
  int mx0[4];
  int mx1[4];
  int mc0, mc1;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int step(input int x, input bit left);
    int nx;
    if (!left) begin
      nx = (x + 2) % 2048;
      if (nx >= 640 && nx <= 1023) nx = (nx - 720 + 2048) % 2048;
    end else begin
      nx = (x - 2 + 2048) % 2048;
      if (nx >= 1024 && nx <= 1968) nx = nx + 720 - 2048;
    end
    return nx;
  endfunction

  function automatic int hit(input int x, input int fx, input int fy, input int fw, input int fh);
    int l, r;
    l = (x < 1024) ? x : 0;
    r = (x + 80) % 2048;
    return (fx <= r && l <= fx + fw && fy <= 320 && 280 <= fy + fh) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mx0[0] = 0; mx0[1] = 213; mx0[2] = 426; mx0[3] = 0;
    mx1[0] = 0; mx1[1] = 200; mx1[2] = 400; mx1[3] = 600;
    mc0 = 0; mc1 = 0;
  endtask

  task automatic model_frame(input int fx, input int fy, input int fw, input int fh);
    mc0 = 0; mc1 = 0;
    for (int i = 0; i < 3; i++) begin
      mx0[i] = step(mx0[i], 1'b0);
      if (hit(mx0[i], fx, fy, fw, fh) != 0) mc0 = 1;
    end
    for (int i = 0; i < 4; i++) begin
      mx1[i] = step(mx1[i], 1'b1);
      if (hit(mx1[i], fx, fy, fw, fh) != 0) mc1 = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s dut0 Car_X[%0d]", tag, i), int'(cx0[i]), mx0[i]);
      check($sformatf("%s dut1 Car_X[%0d]", tag, i), int'(cx1[i]), mx1[i]);
      check($sformatf("%s dut0 Car_Y[%0d]", tag, i), int'(cy0[i]), (i < 3) ? 280 : 0);
      check($sformatf("%s dut1 Car_Y[%0d]", tag, i), int'(cy1[i]), 280);
    end
    check({tag, " dut0 Collision"}, int'(coll0), mc0);
    check({tag, " dut1 Collision"}, int'(coll1), mc1);
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_clk = 1'b0; Enable = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic tick(input logic en, input int fx, input int fy, input int fw, input int fh,
                      input string tag);
    Enable = en;
    FrogX = 11'(fx); FrogY = 11'(fy); FrogW = 11'(fw); FrogH = 11'(fh);
    frame_clk = 1'b1;
    repeat (20) @(negedge clk);
    check({tag, " dut0 Busy idle"}, int'(busy0), 0);
    check({tag, " dut1 Busy idle"}, int'(busy1), 0);
    frame_clk = 1'b0;
    repeat (5) @(negedge clk);
    if (en) model_frame(fx, fy, fw, fh);
    compare_all(tag);
  endtask

  // Waits up to 10 cycles for dut0 Busy; returns the cycle count (11 on timeout).
  task automatic wait_busy(output int k);
    k = 11;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (busy0) begin
        k = j;
        break;
      end
    end
  endtask

  typedef struct {
    logic en;
    int   fx, fy, fw, fh;
    int   exp_x0;
    int   exp_coll;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k, bcnt, cat;

    tbl[0] = '{1'b1, 300, 440, 40, 40,  2, 0};
    tbl[1] = '{1'b1, 220, 290, 40, 40,  4, 1};
    tbl[2] = '{1'b0,   0,   0,  0,  0,  4, 1};
    tbl[3] = '{1'b1, 220, 440, 40, 40,  6, 0};
    tbl[4] = '{1'b1,  88, 320,  0,  0,  8, 1};
    tbl[5] = '{1'b1,  91, 320,  0,  0, 10, 0};
    tbl[6] = '{1'b1,   0, 240, 12, 40, 12, 1};
    tbl[7] = '{1'b1,   0, 240, 13, 39, 14, 0};

    FrogX = '0; FrogY = '0; FrogW = '0; FrogH = '0;
    do_reset();

    // Reset state
    check("rst dut0 Car_X[0]", int'(cx0[0]), 0);
    check("rst dut0 Car_X[1]", int'(cx0[1]), 213);
    check("rst dut0 Car_X[2]", int'(cx0[2]), 426);
    check("rst dut0 Car_X[3]", int'(cx0[3]), 0);
    check("rst dut0 Car_Y[0]", int'(cy0[0]), 280);
    check("rst dut0 Car_Y[3]", int'(cy0[3]), 0);
    check("rst dut0 Number_Cars", int'(nc0), 3);
    check("rst dut0 Busy", int'(busy0), 0);
    check("rst dut0 Collision", int'(coll0), 0);
    check("rst dut1 Car_X[3]", int'(cx1[3]), 600);
    check("rst dut1 Number_Cars", int'(nc1), 4);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      tick(tbl[v].en, tbl[v].fx, tbl[v].fy, tbl[v].fw, tbl[v].fh, $sformatf("tbl%0d", v));
      check($sformatf("tbl%0d Car_X[0]", v), int'(cx0[0]), tbl[v].exp_x0);
      check($sformatf("tbl%0d Collision", v), int'(coll0), tbl[v].exp_coll);
    end

    // Detection latency, Busy length and Collision latency
    do_reset();
    Enable = 1'b1; FrogX = 11'd220; FrogY = 11'd290; FrogW = 11'd40; FrogH = 11'd40;
    frame_clk = 1'b1;
    wait_busy(k);
    check("detect latency", k, 3);
    bcnt = 1; cat = -1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (coll0 && cat < 0) cat = j;
    end
    check("busy cycles", bcnt, 8);
    check("collision latency", cat, 8);
    frame_clk = 1'b0;
    repeat (5) @(negedge clk);
    model_frame(220, 290, 40, 40);
    compare_all("lat");
    tick(1'b1, 220, 440, 40, 40, "frog_away");
    check("frog_away Collision", int'(coll0), 0);

    // Reset mid-MOVE
    tick(1'b1, 220, 290, 40, 40, "pre_rst");
    check("pre_rst Collision", int'(coll0), 1);
    frame_clk = 1'b1;
    wait_busy(k);
    check("pre_rst detect", k, 3);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("midrst dut0 Car_X[0]", int'(cx0[0]), 0);
    check("midrst dut0 Car_X[1]", int'(cx0[1]), 213);
    check("midrst dut0 Car_X[2]", int'(cx0[2]), 426);
    check("midrst dut0 Busy", int'(busy0), 0);
    check("midrst dut0 Collision", int'(coll0), 0);
    check("midrst dut1 Busy", int'(busy1), 0);
    check("midrst dut1 Collision", int'(coll1), 0);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    model_reset();

    // Second rise during CHECK is dropped; Enable drop mid-update does not abort
    FrogX = 11'd300; FrogY = 11'd440; FrogW = 11'd40; FrogH = 11'd40;
    Enable = 1'b1;
    frame_clk = 1'b1;
    wait_busy(k);
    check("drop detect", k, 3);
    frame_clk = 1'b0;
    bcnt = 1;
    for (int j = 4; j <= 30; j++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (j == 5) Enable = 1'b0;
      if (j == 7) frame_clk = 1'b1;
      if (j == 9) Enable = 1'b1;
    end
    check("drop busy cycles", bcnt, 8);
    frame_clk = 1'b0;
    repeat (5) @(negedge clk);
    check("drop dut0 Car_X[0]", int'(cx0[0]), 2);
    check("drop dut1 Car_X[0]", int'(cx1[0]), 2046);
    model_frame(300, 440, 40, 40);
    compare_all("drop");

    // Wrap boundaries, random frog
    do_reset();
    for (int t = 1; t <= 108; t++) begin
      tick(1'b1, $urandom_range(0, 700), $urandom_range(200, 360),
           $urandom_range(0, 60), $urandom_range(0, 60), $sformatf("wrap%0d", t));
      if (t == 39)  check("left wrap -78", int'(cx1[0]), 1970);
      if (t == 40)  check("left wrap 640", int'(cx1[0]), 640);
      if (t == 107) check("right wrap -80", int'(cx0[2]), 1968);
      if (t == 108) check("right wrap -78", int'(cx0[2]), 1970);
    end

    // Random enable and frog
    for (int t = 0; t < 60; t++) begin
      tick(($urandom_range(0, 3) != 0), $urandom_range(0, 700), $urandom_range(200, 360),
           $urandom_range(0, 60), $urandom_range(0, 60), $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
